inst_cache: RTL

//  Direct-mapped, one-word-per-line instruction cache between the fetch unit and MemCtrl.

---
 rtl/inst_cache_if.sv | 32 +++
 rtl/inst_cache.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/inst_cache_if.sv
// inst_cache_if
//  Groups the two bus-style connections of the instruction cache.
//  Fetch side:
//    if_req, if_pc, clr  -> into the cache
//    if_valid, if_inst   <- out of the cache
//  MemCtrl ICache port:
//    mc_addr, mc_req     <- out of the cache (addr_target / ic_flag)
//    mc_data, mc_done    -> into the cache (ic_val_out / ic_isok)
//  Modports:
//    slave  - the cache itself
//    master - the surroundings (fetch unit plus MemCtrl, or a testbench)
interface inst_cache_if;
  logic        if_req;
  logic [31:0] if_pc;
  logic        clr;
  logic        if_valid;
  logic [31:0] if_inst;
  logic [31:0] mc_addr;
  logic        mc_req;
  logic [31:0] mc_data;
  logic        mc_done;

  modport slave (
    input  if_req, if_pc, clr, mc_data, mc_done,
    output if_valid, if_inst, mc_addr, mc_req
  );

  modport master (
    output if_req, if_pc, clr, mc_data, mc_done,
    input  if_valid, if_inst, mc_addr, mc_req
  );
endinterface

// File: rtl/inst_cache.sv
// inst_cache
//  Direct-mapped instruction cache with one 32-bit word per line, sitting
//  between the fetch unit and MemCtrl. Hits return in one cycle. A miss
//  raises mc_req with the word address until MemCtrl pulses mc_done. The
//  line is then filled and the word is returned to fetch, unless a flush
//  arrived while the refill was outstanding.
//  Ports:
//    clk  - clock, all state changes on the rising edge
//    rst  - synchronous active-high reset, takes priority over rdy
//    rdy  - global enable; when low every register and the arrays hold
//    bus  - inst_cache_if.slave carrying the fetch and MemCtrl signals
//  Parameter:
//    INDEX_BITS - line-index width; 2**INDEX_BITS lines, tag = 30-INDEX_BITS bits
module inst_cache #(
  parameter int INDEX_BITS = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         rdy,
  inst_cache_if.slave  bus
);

  localparam int LINES    = 1 << INDEX_BITS;
  localparam int TAG_BITS = 30 - INDEX_BITS;

  typedef enum logic {
    IDLE,
    MISS
  } state_t;

  state_t state_q, state_d;

  logic [31:0]         data_mem [LINES];
  logic [TAG_BITS-1:0] tag_mem  [LINES];
  logic [LINES-1:0]    valid_q;

  // Word address (pc[31:2]) of the outstanding refill.
  logic [29:0] pend_q, pend_d;
  // Set by a flush during MISS; suppresses the return to fetch.
  logic        drop_q, drop_d;

  logic        if_valid_q, if_valid_d;
  logic [31:0] if_inst_q, if_inst_d;
  logic        mc_req_q, mc_req_d;
  logic [31:0] mc_addr_q, mc_addr_d;
  logic        fill_en;

  logic [INDEX_BITS-1:0] req_idx, pend_idx;
  logic [TAG_BITS-1:0]   req_tag, pend_tag;
  logic                  hit;
  logic                  unused_pc_bits;

  assign req_idx  = bus.if_pc[INDEX_BITS+1:2];
  assign req_tag  = bus.if_pc[31:INDEX_BITS+2];
  assign pend_idx = pend_q[INDEX_BITS-1:0];
  assign pend_tag = pend_q[29:INDEX_BITS];
  assign hit      = valid_q[req_idx] && (tag_mem[req_idx] == req_tag);

  // The byte offset within a word is irrelevant to an aligned fetch.
  assign unused_pc_bits = ^bus.if_pc[1:0];

  assign bus.if_valid = if_valid_q;
  assign bus.if_inst  = if_inst_q;
  assign bus.mc_req   = mc_req_q;
  assign bus.mc_addr  = mc_addr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else if (rdy) begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    if_valid_d = 1'b0;
    if_inst_d  = if_inst_q;
    mc_req_d   = mc_req_q;
    mc_addr_d  = mc_addr_q;
    pend_d     = pend_q;
    drop_d     = drop_q;
    fill_en    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.if_req && !bus.clr) begin
          if (hit) begin
            if_valid_d = 1'b1;
            if_inst_d  = data_mem[req_idx];
          end else begin
            mc_addr_d = {bus.if_pc[31:2], 2'b00};
            mc_req_d  = 1'b1;
            pend_d    = bus.if_pc[31:2];
            drop_d    = 1'b0;
            state_d   = MISS;
          end
        end
      end

      MISS: begin
        if (bus.clr) begin
          drop_d = 1'b1;
        end
        if (bus.mc_done) begin
          // MemCtrl cannot abort, so the line is written even after a flush.
          fill_en  = 1'b1;
          mc_req_d = 1'b0;
          drop_d   = 1'b0;
          state_d  = IDLE;
          if (!drop_q && !bus.clr) begin
            if_valid_d = 1'b1;
            if_inst_d  = bus.mc_data;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q    <= '0;
      pend_q     <= '0;
      drop_q     <= 1'b0;
      if_valid_q <= 1'b0;
      if_inst_q  <= '0;
      mc_req_q   <= 1'b0;
      mc_addr_q  <= '0;
    end else if (rdy) begin
      pend_q     <= pend_d;
      drop_q     <= drop_d;
      if_valid_q <= if_valid_d;
      if_inst_q  <= if_inst_d;
      mc_req_q   <= mc_req_d;
      mc_addr_q  <= mc_addr_d;
      if (fill_en) begin
        valid_q[pend_idx] <= 1'b1;
      end
    end
  end

  // Data and tag carry no reset; the valid bits guard them.
  always_ff @(posedge clk) begin
    if (!rst && rdy && fill_en) begin
      data_mem[pend_idx] <= bus.mc_data;
      tag_mem[pend_idx]  <= pend_tag;
    end
  end

endmodule
